fir_sched: RTL



---
 rtl/fir_sched.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/fir_sched.sv
// fir_sched: sequencing controller for the AHB FIR datapath.
// Loads TAPS coefficients from memory into the FIR, then meters samples
// through the FIR one at a time and buffers each result behind a
// valid/ready handshake.
// Optional feature: define FIR_SCHED_CNT_EN to add the 16-bit out_cnt port
// counting completed output transfers.
module fir_sched #(
  parameter int TAPS           = 20,
  parameter int BIT_PREC       = 8,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int MEM_WIDTH      = 32,
  parameter int OUT_SIZE       = 2*BIT_PREC+$clog2(TAPS-1)
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      start,
  input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
  output logic                      mem_re,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [MEM_WIDTH-1:0]      mem_rdata,
  output logic                      coef_we,
  output logic [$clog2(TAPS)-1:0]   coef_idx,
  output logic [BIT_PREC-1:0]       coef_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [BIT_PREC-1:0]       s_data,
  output logic                      fir_en,
  output logic [BIT_PREC-1:0]       fir_din,
  input  logic [OUT_SIZE-1:0]       fir_dout,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [OUT_SIZE-1:0]       m_data,
  output logic                      busy,
  output logic                      loaded,
`ifdef FIR_SCHED_CNT_EN
  output logic                      err,
  output logic [15:0]               out_cnt
`else
  output logic                      err
`endif
);

  localparam int IDX_W = $clog2(TAPS);
  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(TAPS-1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] LAST = 2'd2;
  localparam logic [1:0] RUN  = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [IDX_W-1:0]          k_q, k_d;
  logic [MEM_ADDR_WIDTH-1:0] base_q, base_d;
  logic                      coefWe_q, coefWe_d;
  logic [IDX_W-1:0]          coefIdx_q, coefIdx_d;
  logic                      loaded_q, loaded_d;
  logic                      err_q, err_d;
  logic                      inflight_q, inflight_d;
  logic                      mValid_q, mValid_d;
  logic [OUT_SIZE-1:0]       mData_q, mData_d;

  logic inLoad;
  logic inRun;
  logic startOk;
  logic startBad;
  logic slotFree;
  logic sReady;
  logic accept;
  logic xfer;
  logic unusedRdata;

  // Handshake qualifiers: a start is honoured only in IDLE or in RUN with no
  // sample inside the FIR, and a simultaneous start blocks sample acceptance.
  always_comb begin
    inLoad   = (state_q == LOAD);
    inRun    = (state_q == RUN);
    startOk  = start && ((state_q == IDLE) || (inRun && !inflight_q));
    startBad = start && !startOk;
    slotFree = !mValid_q || m_ready;
    sReady   = inRun && !inflight_q && slotFree && !start;
    accept   = s_valid && sReady;
    xfer     = mValid_q && m_ready;
  end

  // Sequencer: walk k through the coefficient addresses, then settle in RUN.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    base_d   = base_q;
    loaded_d = loaded_q;
    case (state_q)
      IDLE, RUN: begin
        if (startOk) begin
          state_d  = LOAD;
          k_d      = '0;
          base_d   = base_addr;
          loaded_d = 1'b0;
        end
      end
      LOAD: begin
        if (k_q == LAST_K) begin
          state_d = LAST;
        end else begin
          k_d = k_q + IDX_W'(1);
        end
      end
      LAST: begin
        state_d  = RUN;
        loaded_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath next state: coefficient write follows each read by one cycle,
  // and the output slot is claimed at acceptance and filled from the FIR
  // during the following (inflight) cycle.
  always_comb begin
    coefWe_d   = inLoad;
    coefIdx_d  = inLoad ? k_q : coefIdx_q;
    err_d      = startBad;
    inflight_d = accept;
    mValid_d   = mValid_q;
    if (xfer) begin
      mValid_d = 1'b0;
    end
    if (accept) begin
      mValid_d = 1'b1;
    end
    mData_d = inflight_q ? fir_dout : mData_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= IDLE;
      k_q        <= '0;
      base_q     <= '0;
      coefWe_q   <= 1'b0;
      coefIdx_q  <= '0;
      loaded_q   <= 1'b0;
      err_q      <= 1'b0;
      inflight_q <= 1'b0;
      mValid_q   <= 1'b0;
      mData_q    <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      base_q     <= base_d;
      coefWe_q   <= coefWe_d;
      coefIdx_q  <= coefIdx_d;
      loaded_q   <= loaded_d;
      err_q      <= err_d;
      inflight_q <= inflight_d;
      mValid_q   <= mValid_d;
      mData_q    <= mData_d;
    end
  end

`ifdef FIR_SCHED_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Transfer counter: cleared when a new load begins, saturating at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (startOk) begin
      cnt_d = '0;
    end else if (xfer && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_cnt = cnt_q;
`endif

  // Only the low BIT_PREC bits of a memory word carry a coefficient.
  assign unusedRdata = ^mem_rdata;

  assign mem_re    = inLoad;
  assign mem_addr  = inLoad ? (base_q + MEM_ADDR_WIDTH'(k_q)) : '0;
  assign coef_we   = coefWe_q;
  assign coef_idx  = coefIdx_q;
  assign coef_data = coefWe_q ? mem_rdata[BIT_PREC-1:0] : '0;
  assign s_ready   = sReady;
  assign fir_en    = accept;
  assign fir_din   = accept ? s_data : '0;
  assign m_valid   = mValid_q;
  assign m_data    = inflight_q ? fir_dout : mData_q;
  assign busy      = inLoad || (state_q == LAST);
  assign loaded    = loaded_q;
  assign err       = err_q;

endmodule
